// File: rtl/digit_scan_controller.sv
// digit_scan_controller: free-running multiplexed 7-segment digit scanner.
// Cycles the digit position, drives a one-hot select and inserts dead-time.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_blank        1 = all selects inactive, scanning keeps running
//   i_digit_mask   bit k = 1 enables digit k
//   o_digit_pos    current digit index (registered)
//   o_select       one-hot select, polarity set by ACTIVE_LOW (registered)
//   o_scan_tick    one-cycle pulse in the last cycle of each slot
//
// Optional feature macro: DIGIT_SCAN_SKIP_MASKED_EN
//   defined   -> slot advance jumps to the next unmasked digit
//   undefined -> every digit gets a slot, masked slots stay dark
module digit_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int SCAN_DIV    = 100000,
   parameter int DEAD_CYCLES = 500,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_blank,
   input  logic [NUM_DIGITS-1:0]         i_digit_mask,
   output logic [$clog2(NUM_DIGITS)-1:0] o_digit_pos,
   output logic [NUM_DIGITS-1:0]         o_select,
   output logic                          o_scan_tick
);

   localparam int PW = $clog2(NUM_DIGITS);
   localparam int DW = $clog2(SCAN_DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] IDLE_SEL =
      (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic {
      ST_DEAD,
      ST_ON
   } state_t;

   state_t          state;
   state_t          nxt_state;
   logic [DW-1:0]   div_cnt;
   logic [DW-1:0]   nxt_div;
   logic [PW-1:0]   pos;
   logic [PW-1:0]   nxt_pos;
   logic            slot_end;
   logic            lit;
   logic [NUM_DIGITS-1:0] hot;
   logic [NUM_DIGITS-1:0] nxt_sel;

   function automatic logic [PW-1:0] inc_pos(input logic [PW-1:0] p);
      return (p == POS_LAST) ? '0 : p + 1'b1;
   endfunction

   // First enabled index searched cyclically from p+1; plain
   // increment when nothing is enabled.
   function automatic logic [PW-1:0] next_lit(
      input logic [PW-1:0]         p,
      input logic [NUM_DIGITS-1:0] m
   );
      logic [PW-1:0] q;
      logic [PW-1:0] r;
      logic          found;
      q     = p;
      r     = inc_pos(p);
      found = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         q = inc_pos(q);
         if (!found && m[q]) begin
            r     = q;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Outputs are registered from the next (pos, div_cnt) so every
   // output in a cycle describes the same slot position.
   always_comb begin
      slot_end = (div_cnt == DIV_LAST);
      nxt_div  = slot_end ? '0 : div_cnt + 1'b1;
      nxt_pos  = pos;
      if (slot_end) begin
`ifdef DIGIT_SCAN_SKIP_MASKED_EN
         nxt_pos = next_lit(pos, i_digit_mask);
`else
         nxt_pos = inc_pos(pos);
`endif
      end
      nxt_state = state;
      unique case (state)
         ST_DEAD: begin
            if (int'(nxt_div) >= DEAD_CYCLES)
               nxt_state = ST_ON;
         end
         ST_ON: begin
            if (slot_end && DEAD_CYCLES > 0)
               nxt_state = ST_DEAD;
         end
         default: nxt_state = ST_DEAD;
      endcase
      lit = (nxt_state == ST_ON) && !i_blank
            && i_digit_mask[nxt_pos];
      hot = '0;
      if (lit)
         hot = NUM_DIGITS'(1) << nxt_pos;
      nxt_sel = (ACTIVE_LOW != 0) ? ~hot : hot;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= ST_DEAD;
         div_cnt     <= '0;
         pos         <= '0;
         o_select    <= IDLE_SEL;
         o_scan_tick <= 1'b0;
      end else begin
         state       <= nxt_state;
         div_cnt     <= nxt_div;
         pos         <= nxt_pos;
         o_select    <= nxt_sel;
         o_scan_tick <= (nxt_div == DIV_LAST);
      end
   end

   assign o_digit_pos = pos;

endmodule
